pia_bus_arbiter: RTL and testbench

PIA_BUS_ARBITER -- requirements
Module: pia_bus_arbiter

---
 rtl/pia_bus_pkg.sv | 20 ++
 rtl/pia_bus_arbiter.sv | 178 +++++++++++++++++
 tb/tb_pia_bus_arbiter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/pia_bus_pkg.sv
// Shared types and constants for the 8255 PIA bus arbiter.
package pia_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic [7:0] CTRL_RESET      = 8'h9B;
  localparam logic [1:0] CTRL_ADDR       = 2'b11;
  localparam int         STB_LEN_DEFAULT = 2;

  // A mode-set word is a control-register write with D[7] set; bit set/reset words are not.
  function automatic logic is_mode_set(input logic we, input logic [1:0] a, input logic [7:0] d);
    return we && (a == CTRL_ADDR) && d[7];
  endfunction

endpackage

// File: rtl/pia_bus_arbiter.sv
// Two-requester round-robin arbiter sequencing SETUP/STROBE/HOLD accesses to an 8255 PIA.
module pia_bus_arbiter
  import pia_bus_pkg::*;
#(
  parameter int STB_LEN = STB_LEN_DEFAULT
) (
  input  logic       I_CLK,
  input  logic       I_RESET,
  input  logic       I_REQ0,
  input  logic       I_REQ1,
  input  logic       I_WE0,
  input  logic       I_WE1,
  input  logic [1:0] I_A0,
  input  logic [1:0] I_A1,
  input  logic [7:0] I_D0,
  input  logic [7:0] I_D1,
  output logic       O_ACK0,
  output logic       O_ACK1,
  output logic [7:0] O_Q0,
  output logic [7:0] O_Q1,
  output logic       O_PIA_CS,
  output logic       O_PIA_WR,
  output logic       O_PIA_RD,
  output logic [1:0] O_PIA_A,
  output logic [7:0] O_PIA_D,
  input  logic [7:0] I_PIA_Q,
  output logic       O_BUSY,
  output logic [7:0] O_CTRL
);

  localparam logic [3:0] STB_LOAD = 4'(STB_LEN - 1);

  state_t     state_r, state_s;
  logic [3:0] cnt_r, cnt_s;
  logic       ptr_r, ptr_s;
  logic       gnt_r, gnt_s;
  logic       we_r, we_s;
  logic [1:0] a_r, a_s;
  logic [7:0] d_r, d_s;
  logic [7:0] q0_r, q0_s;
  logic [7:0] q1_r, q1_s;
  logic [7:0] ctrl_r, ctrl_s;
  logic       cs_r, cs_s;
  logic       wr_r, wr_s;
  logic       rd_r, rd_s;
  logic       ack0_r, ack0_s;
  logic       ack1_r, ack1_s;
  logic       busy_r, busy_s;
  logic       pick_s;

  // Round-robin picker: on a tie the requester not granted last wins.
  always_comb begin
    pick_s = 1'b0;
    if (I_REQ0 && I_REQ1) begin
      pick_s = ~ptr_r;
    end else if (I_REQ1) begin
      pick_s = 1'b1;
    end else begin
      pick_s = 1'b0;
    end
  end

  // Next-state, latch and registered-output logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    ptr_s   = ptr_r;
    gnt_s   = gnt_r;
    we_s    = we_r;
    a_s     = a_r;
    d_s     = d_r;
    q0_s    = q0_r;
    q1_s    = q1_r;
    ctrl_s  = ctrl_r;
    case (state_r)
      IDLE: begin
        if (I_REQ0 || I_REQ1) begin
          gnt_s   = pick_s;
          ptr_s   = pick_s;
          we_s    = pick_s ? I_WE1 : I_WE0;
          a_s     = pick_s ? I_A1 : I_A0;
          d_s     = pick_s ? I_D1 : I_D0;
          state_s = SETUP;
        end else begin
          state_s = IDLE;
        end
      end
      SETUP: begin
        cnt_s   = STB_LOAD;
        state_s = STROBE;
      end
      STROBE: begin
        if (cnt_r == 4'd0) begin
          state_s = HOLD;
          if (!we_r && gnt_r) begin
            q1_s = I_PIA_Q;
          end else if (!we_r) begin
            q0_s = I_PIA_Q;
          end else begin
            q0_s = q0_r;
          end
          if (is_mode_set(we_r, a_r, d_r)) begin
            ctrl_s = d_r;
          end else begin
            ctrl_s = ctrl_r;
          end
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      HOLD: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    // Strobes and ACK are registered copies of what the next state implies.
    cs_s   = (state_s != IDLE);
    busy_s = (state_s != IDLE);
    wr_s   = (state_s == STROBE) && we_s;
    rd_s   = (state_s == STROBE) && !we_s;
    ack0_s = (state_s == HOLD) && !gnt_s;
    ack1_s = (state_s == HOLD) && gnt_s;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      ptr_r   <= 1'b1;
      gnt_r   <= 1'b0;
      we_r    <= 1'b0;
      a_r     <= 2'd0;
      d_r     <= 8'h00;
      q0_r    <= 8'h00;
      q1_r    <= 8'h00;
      ctrl_r  <= CTRL_RESET;
      cs_r    <= 1'b0;
      wr_r    <= 1'b0;
      rd_r    <= 1'b0;
      ack0_r  <= 1'b0;
      ack1_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      ptr_r   <= ptr_s;
      gnt_r   <= gnt_s;
      we_r    <= we_s;
      a_r     <= a_s;
      d_r     <= d_s;
      q0_r    <= q0_s;
      q1_r    <= q1_s;
      ctrl_r  <= ctrl_s;
      cs_r    <= cs_s;
      wr_r    <= wr_s;
      rd_r    <= rd_s;
      ack0_r  <= ack0_s;
      ack1_r  <= ack1_s;
      busy_r  <= busy_s;
    end
  end

  assign O_ACK0   = ack0_r;
  assign O_ACK1   = ack1_r;
  assign O_Q0     = q0_r;
  assign O_Q1     = q1_r;
  assign O_PIA_CS = cs_r;
  assign O_PIA_WR = wr_r;
  assign O_PIA_RD = rd_r;
  assign O_PIA_A  = a_r;
  assign O_PIA_D  = d_r;
  assign O_BUSY   = busy_r;
  assign O_CTRL   = ctrl_r;

endmodule

// File: tb/tb_pia_bus_arbiter.sv
// Randomized bench: a transaction-timing model predicts every cycle's bus and the ACK stream.
module tb_pia_bus_arbiter;

  localparam int STB = 2;
  localparam int NCYC = 4000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req = 2'b00;
  logic [1:0] we = 2'b00;
  logic [1:0] a [2];
  logic [7:0] d [2];
  logic [7:0] pia_q = 8'h00;

  logic       ack0, ack1, cs, wr, rd, busy;
  logic [7:0] q0, q1, pd, ctrl;
  logic [1:0] pa;

  pia_bus_arbiter #(.STB_LEN(STB)) dut (
    .I_CLK(clk), .I_RESET(rst),
    .I_REQ0(req[0]), .I_REQ1(req[1]),
    .I_WE0(we[0]), .I_WE1(we[1]),
    .I_A0(a[0]), .I_A1(a[1]),
    .I_D0(d[0]), .I_D1(d[1]),
    .O_ACK0(ack0), .O_ACK1(ack1),
    .O_Q0(q0), .O_Q1(q1),
    .O_PIA_CS(cs), .O_PIA_WR(wr), .O_PIA_RD(rd),
    .O_PIA_A(pa), .O_PIA_D(pd), .I_PIA_Q(pia_q),
    .O_BUSY(busy), .O_CTRL(ctrl)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; logic who;} sb_t;
  sb_t sbq[$];

  logic [39:0] exp_bus [NCYC+8];
  bit          exp_valid [NCYC+8];
  int          cyc = 0;
  bit          started = 1'b0;
  int          checks = 0;
  int          passed = 0;

  // requester states: 0 idle, 1 waiting, 2 granted (per model)
  int rs [2];
  int ack_at [2];

  // reference model state
  int         m_free_at, t_g;
  bit         t_active, t_we, t_who, m_last;
  logic [1:0] m_a, t_a;
  logic [7:0] m_d, t_d, m_ctrl;
  logic [7:0] m_q [2];

  function automatic logic [39:0] mk(input bit c, input bit w, input bit r, input bit k0,
                                     input bit k1, input bit b, input logic [1:0] aa,
                                     input logic [7:0] dd, input logic [7:0] x0,
                                     input logic [7:0] x1, input logic [7:0] cc);
    return {c, w, r, k0, k1, b, aa, dd, x0, x1, cc};
  endfunction

  task automatic new_req(input int i);
    if ($urandom_range(0, 3) == 0) begin
      we[i] = 1'b1;
      a[i]  = 2'd3;
    end else begin
      we[i] = 1'($urandom_range(0, 1));
      a[i]  = 2'($urandom_range(0, 3));
    end
    d[i] = 8'($urandom);
  endtask

  task automatic model_step(input int k);
    int p;
    bit strobe;
    if (rst) begin
      t_active = 1'b0;
      m_free_at = k + 1;
      m_last = 1'b1;
      m_a = 2'd0;
      m_d = 8'h00;
      m_q[0] = 8'h00;
      m_q[1] = 8'h00;
      m_ctrl = 8'h9B;
      while (sbq.size() > 0 && sbq[$].cyc > k) void'(sbq.pop_back());
    end else begin
      if (t_active && k == t_g + 1 + STB) begin
        if (!t_we) m_q[t_who] = pia_q;
        if (t_we && t_a == 2'd3 && t_d[7]) m_ctrl = t_d;
        sbq.push_back('{cyc: k + 1, who: t_who});
      end
      if (t_active && k == t_g + STB + 2) t_active = 1'b0;
      if (!t_active && k >= m_free_at && (req[0] || req[1])) begin
        if (req[0] && req[1]) t_who = ~m_last;
        else t_who = req[1];
        m_last = t_who;
        t_we = we[t_who];
        t_a = a[t_who];
        t_d = d[t_who];
        m_a = t_a;
        m_d = t_d;
        t_g = k;
        t_active = 1'b1;
        m_free_at = k + STB + 3;
        rs[t_who] = 2;
        ack_at[t_who] = k + STB + 2;
      end
    end
    if (t_active && !rst) begin
      p = k + 1 - t_g;
      strobe = (p >= 2) && (p <= STB + 1);
      exp_bus[k+1] = mk(1'b1, strobe && t_we, strobe && !t_we, (p == STB + 2) && !t_who,
                        (p == STB + 2) && t_who, 1'b1, m_a, m_d, m_q[0], m_q[1], m_ctrl);
    end else begin
      exp_bus[k+1] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, m_a, m_d, m_q[0], m_q[1], m_ctrl);
    end
    exp_valid[k+1] = 1'b1;
  endtask

  // Stimulus: requesters follow the handshake, phase 1 keeps both requesting continuously.
  initial begin
    bit both;
    a[0] = 2'd0; a[1] = 2'd0; d[0] = 8'h00; d[1] = 8'h00;
    rs[0] = 0; rs[1] = 0; ack_at[0] = -1; ack_at[1] = -1;
    t_active = 1'b0; m_free_at = 0; m_last = 1'b1;
    for (int k = 0; k < NCYC; k++) begin
      @(posedge clk);
      #1;
      cyc = k;
      started = 1'b1;
      both = (k < 200);
      rst = (k < 3) || (!both && $urandom_range(0, 119) == 0);
      pia_q = 8'($urandom);
      if (rst) begin
        req = 2'b00;
        rs[0] = 0;
        rs[1] = 0;
      end else begin
        for (int i = 0; i < 2; i++) begin
          case (rs[i])
            0: if (both || $urandom_range(0, 2) == 0) begin
                 new_req(i); req[i] = 1'b1; rs[i] = 1;
               end
            1: if (!both && $urandom_range(0, 15) == 0) begin
                 req[i] = 1'b0; rs[i] = 0;
               end
            default: begin
              if (k == ack_at[i]) begin
                if (both || $urandom_range(0, 1) == 0) begin
                  new_req(i); req[i] = 1'b1; rs[i] = 1;
                end else begin
                  req[i] = 1'b0; rs[i] = 0;
                end
              end else begin
                we[i] = 1'($urandom_range(0, 1));
                a[i] = 2'($urandom_range(0, 3));
                d[i] = 8'($urandom);
                if (!both && $urandom_range(0, 3) == 0) req[i] = 1'b0;
              end
            end
          endcase
        end
      end
      model_step(k);
    end
    @(posedge clk);
    started = 1'b0;
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Monitor: per-cycle bus comparison and ACK scoreboard.
  always @(negedge clk) begin
    logic [39:0] act;
    if (started) begin
      act = {cs, wr, rd, ack0, ack1, busy, pa, pd, q0, q1, ctrl};
      if (exp_valid[cyc]) begin
        checks++;
        if (act === exp_bus[cyc]) passed++;
        else $display("FAIL bus cycle %0d: got %h want %h", cyc, act, exp_bus[cyc]);
      end
      while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
        checks++;
        $display("FAIL missed_ack cycle %0d: got none want ack%0d", sbq[0].cyc, sbq[0].who);
        void'(sbq.pop_front());
      end
      if (ack0 || ack1) begin
        checks++;
        if (sbq.size() == 0) begin
          $display("FAIL spurious_ack cycle %0d: got ack0=%0b ack1=%0b want none", cyc, ack0, ack1);
        end else if (sbq[0].cyc == cyc && ack1 == sbq[0].who && ack0 == !sbq[0].who) begin
          passed++;
          void'(sbq.pop_front());
        end else begin
          $display("FAIL ack cycle %0d: got ack0=%0b ack1=%0b want ack%0d at cycle %0d",
                   cyc, ack0, ack1, sbq[0].who, sbq[0].cyc);
          void'(sbq.pop_front());
        end
      end
    end
  end

endmodule
